// File: rtl/lsu_misalign_seq.sv
// ---------------------------------------------------------------------------
// lsu_misalign_seq
//
// Load/store sequencer that sits between the execute stage and the data RAM
// port. It takes one request at a time. Aligned accesses become a single
// native RAM operation. Misaligned halfword/word accesses are either broken
// into a run of byte operations (LBU / SB), merged and extended, or reported
// as misaligned exceptions, depending on SPLIT_MISALIGNED.
//
// Ports
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_req_valid/o_req_ready request handshake
//   i_req_load/i_req_store  request kind
//   i_req_funct3            access type (RISC-V funct3 encoding)
//   i_req_addr/i_req_wdata  byte address and store data
//   i_flush                 trap/kill, aborts the in-flight operation
//   o_resp_valid            one-cycle completion pulse
//   o_resp_rdata            load result (0 for stores / exceptions)
//   o_load_misaligned       misaligned-load flag, valid with o_resp_valid
//   o_store_misaligned      misaligned-store flag, valid with o_resp_valid
//   o_busy                  sequencer not idle
//   o_mem_*                 RAM address, write data, enables, ops, exception
//   i_mem_r_data            RAM combinational read data
// ---------------------------------------------------------------------------
module lsu_misalign_seq #(
   parameter int          XLEN             = 32,
   parameter int          SPLIT_MISALIGNED = 1,
   parameter logic [2:0]  F3_LB            = 3'd0,
   parameter logic [2:0]  F3_LH            = 3'd1,
   parameter logic [2:0]  F3_LW            = 3'd2,
   parameter logic [2:0]  F3_LBU           = 3'd4,
   parameter logic [2:0]  F3_LHU           = 3'd5,
   parameter logic [2:0]  F3_SB            = 3'd0,
   parameter logic [2:0]  F3_SH            = 3'd1,
   parameter logic [2:0]  F3_SW            = 3'd2
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic            i_req_load,
   input  logic            i_req_store,
   input  logic [2:0]      i_req_funct3,
   input  logic [XLEN-1:0] i_req_addr,
   input  logic [XLEN-1:0] i_req_wdata,
   input  logic            i_flush,
   output logic            o_resp_valid,
   output logic [XLEN-1:0] o_resp_rdata,
   output logic            o_load_misaligned,
   output logic            o_store_misaligned,
   output logic            o_busy,
   output logic [XLEN-1:0] o_mem_addr,
   output logic [XLEN-1:0] o_mem_w_data,
   output logic            o_mem_load,
   output logic [2:0]      o_mem_load_ops,
   output logic            o_mem_store,
   output logic [2:0]      o_mem_store_ops,
   output logic            o_mem_exception,
   input  logic [XLEN-1:0] i_mem_r_data
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      SPLIT  = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_nextState;

   // Captured request
   logic [XLEN-1:0]   r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic [2:0]        r_funct3;
   logic              r_isLoad;
   logic              r_pendLdMis;
   logic              r_pendStMis;

   // Split progress and merged load data
   logic [1:0]        r_idx;
   logic [1:0]        w_nextIdx;
   logic [1:0]        w_lastIdx;
   logic [XLEN-1:0]   r_buf;

   // Registered outputs
   logic              r_respValid;
   logic [XLEN-1:0]   r_respRdata;
   logic              r_loadMis;
   logic              r_storeMis;
   logic [XLEN-1:0]   r_memAddr;
   logic [XLEN-1:0]   r_memWData;
   logic              r_memLoad;
   logic              r_memStore;
   logic [2:0]        r_memLoadOps;
   logic [2:0]        r_memStoreOps;

   logic              w_accept;
   logic              w_illegal;
   logic              w_misaligned;
   logic              w_flagLd;
   logic              w_flagSt;
   logic              w_enterAccess;
   logic              w_enterSplit;
   logic              w_splitAdvance;
   logic              w_respFire;
   logic [XLEN-1:0]   w_extData;

   assign o_req_ready = (r_state == IDLE) & ~i_flush;
   assign w_accept    = i_req_valid & o_req_ready & (i_req_load | i_req_store);

   // Request decode: legality, natural-alignment check and exception flags
   always_comb begin
      w_illegal    = 1'b0;
      w_misaligned = 1'b0;
      if (i_req_load && i_req_store) begin
         w_illegal = 1'b1;
      end else if (i_req_load) begin
         w_illegal = !((i_req_funct3 == F3_LB)  || (i_req_funct3 == F3_LH) ||
                       (i_req_funct3 == F3_LW)  || (i_req_funct3 == F3_LBU) ||
                       (i_req_funct3 == F3_LHU));
      end else begin
         w_illegal = !((i_req_funct3 == F3_SB) || (i_req_funct3 == F3_SH) ||
                       (i_req_funct3 == F3_SW));
      end
      case (i_req_funct3[1:0])
         2'd1:    w_misaligned = i_req_addr[0];
         2'd2:    w_misaligned = |i_req_addr[1:0];
         default: w_misaligned = 1'b0;
      endcase
      w_flagLd = !w_illegal && w_misaligned && (SPLIT_MISALIGNED == 0) && i_req_load;
      w_flagSt = !w_illegal && w_misaligned && (SPLIT_MISALIGNED == 0) && i_req_store;
   end

   // Last byte index of a split: size-1 (only halfword/word ever split)
   always_comb begin
      case (r_funct3[1:0])
         2'd1:    w_lastIdx = 2'd1;
         2'd2:    w_lastIdx = 2'd3;
         default: w_lastIdx = 2'd0;
      endcase
   end

   assign w_nextIdx = r_idx + 2'd1;

   // Next-state logic; flush overrides everything and cancels RAM activity
   always_comb begin
      w_nextState    = r_state;
      w_enterAccess  = 1'b0;
      w_enterSplit   = 1'b0;
      w_splitAdvance = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_illegal || (w_misaligned && (SPLIT_MISALIGNED == 0))) begin
                  w_nextState = RESP;
               end else if (w_misaligned) begin
                  w_nextState  = SPLIT;
                  w_enterSplit = 1'b1;
               end else begin
                  w_nextState   = ACCESS;
                  w_enterAccess = 1'b1;
               end
            end
         end
         ACCESS: w_nextState = RESP;
         SPLIT: begin
            if (r_idx == w_lastIdx) begin
               w_nextState = RESP;
            end else begin
               w_splitAdvance = 1'b1;
            end
         end
         RESP:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
      if (i_flush) begin
         w_nextState    = IDLE;
         w_enterAccess  = 1'b0;
         w_enterSplit   = 1'b0;
         w_splitAdvance = 1'b0;
      end
   end

   // Final load extension; applied to both the native and the merged path
   always_comb begin
      w_extData = '0;
      if (r_isLoad) begin
         case (r_funct3)
            F3_LB:   w_extData = {{(XLEN-8){r_buf[7]}}, r_buf[7:0]};
            F3_LH:   w_extData = {{(XLEN-16){r_buf[15]}}, r_buf[15:0]};
            F3_LW:   w_extData = r_buf;
            F3_LBU:  w_extData = {{(XLEN-8){1'b0}}, r_buf[7:0]};
            F3_LHU:  w_extData = {{(XLEN-16){1'b0}}, r_buf[15:0]};
            default: w_extData = '0;
         endcase
      end
   end

   assign w_respFire = (r_state == RESP) & ~i_flush;

   // State, captured request, merge buffer and registered outputs.
   // RAM drive registers are loaded one edge ahead so they are valid during
   // the ACCESS/SPLIT cycle they belong to.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state       <= IDLE;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_funct3      <= '0;
         r_isLoad      <= 1'b0;
         r_pendLdMis   <= 1'b0;
         r_pendStMis   <= 1'b0;
         r_idx         <= '0;
         r_buf         <= '0;
         r_respValid   <= 1'b0;
         r_respRdata   <= '0;
         r_loadMis     <= 1'b0;
         r_storeMis    <= 1'b0;
         r_memAddr     <= '0;
         r_memWData    <= '0;
         r_memLoad     <= 1'b0;
         r_memStore    <= 1'b0;
         r_memLoadOps  <= '0;
         r_memStoreOps <= '0;
      end else begin
         r_state     <= w_nextState;
         r_respValid <= w_respFire;
         r_respRdata <= w_respFire ? w_extData : '0;
         r_loadMis   <= w_respFire & r_pendLdMis;
         r_storeMis  <= w_respFire & r_pendStMis;

         if (w_accept) begin
            r_addr      <= i_req_addr;
            r_wdata     <= i_req_wdata;
            r_funct3    <= i_req_funct3;
            r_isLoad    <= i_req_load & ~i_req_store;
            r_pendLdMis <= w_flagLd;
            r_pendStMis <= w_flagSt;
            r_idx       <= '0;
            r_buf       <= '0;
         end else if (w_splitAdvance) begin
            r_idx <= w_nextIdx;
         end

         if ((r_state == ACCESS) && r_isLoad && !i_flush) begin
            r_buf <= i_mem_r_data;
         end else if ((r_state == SPLIT) && r_isLoad && !i_flush) begin
            r_buf[{r_idx, 3'b000} +: 8] <= i_mem_r_data[7:0];
         end

         r_memLoad  <= 1'b0;
         r_memStore <= 1'b0;
         if (w_enterAccess) begin
            r_memAddr  <= i_req_addr;
            r_memLoad  <= i_req_load;
            r_memStore <= i_req_store;
            if (i_req_load) begin
               r_memLoadOps <= i_req_funct3;
            end else begin
               r_memStoreOps <= i_req_funct3;
               r_memWData    <= i_req_wdata;
            end
         end else if (w_enterSplit) begin
            r_memAddr  <= i_req_addr;
            r_memLoad  <= i_req_load;
            r_memStore <= i_req_store;
            if (i_req_load) begin
               r_memLoadOps <= F3_LBU;
            end else begin
               r_memStoreOps <= F3_SB;
               r_memWData    <= {{(XLEN-8){1'b0}}, i_req_wdata[7:0]};
            end
         end else if (w_splitAdvance) begin
            // Address wraps naturally at 2^XLEN
            r_memAddr  <= r_addr + XLEN'(w_nextIdx);
            r_memLoad  <= r_isLoad;
            r_memStore <= ~r_isLoad;
            if (!r_isLoad) begin
               r_memWData <= {{(XLEN-8){1'b0}}, r_wdata[{w_nextIdx, 3'b000} +: 8]};
            end
         end
      end
   end

   assign o_resp_valid       = r_respValid;
   assign o_resp_rdata       = r_respRdata;
   assign o_load_misaligned  = r_loadMis;
   assign o_store_misaligned = r_storeMis;
   assign o_busy             = (r_state != IDLE);
   assign o_mem_addr         = r_memAddr;
   assign o_mem_w_data       = r_memWData;
   assign o_mem_load         = r_memLoad;
   assign o_mem_load_ops     = r_memLoadOps;
   // Flush reaches the RAM combinationally so a store in flight is suppressed
   assign o_mem_store        = r_memStore & ~i_flush;
   assign o_mem_store_ops    = r_memStoreOps;
   assign o_mem_exception    = i_flush;

endmodule
